decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 DATA_WID, 64, width of register values, valC and valP.
REQ-002 ADDR_WID, 4, register-ID width; RNONE = 4'hF means "no register".
REQ-003 CLK  in  1  clock; all state updates on posedge CLK.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 D_stat/D_icode/D_ifun  in  4/4/4  decode-stage status, opcode, function code.
REQ-006 D_rA/D_rB  in  ADDR_WID each  register specifiers; D_valC/D_valP  in  DATA_WID each  constant and next PC.
REQ-007 srcA/srcB  out  ADDR_WID each  combinational read addresses to the register file.
REQ-008 valA/valB  in  DATA_WID each  register file read data for srcA/srcB.
REQ-009 e_dstE,e_valE; M_dstM,m_valM; M_dstE,M_valE; W_dstM,W_valM; W_dstE,W_valE  in  ADDR_WID/DATA_WID pairs  forwarding sources.
REQ-010 E_stall/E_bubble  in  1 each  pipeline control.
REQ-011 E_stat,E_icode,E_ifun,E_valC,E_valA,E_valB,E_dstE,E_dstM,E_srcA,E_srcB  out  registered execute-stage fields.

Function
REQ-012 srcA SHALL be D_rA for icode 2,4,6,A; 4 (RSP) for icode 9,B; else RNONE.
REQ-013 srcB SHALL be D_rB for icode 4,5,6; 4 for icode 8,9,A,B; else RNONE.
REQ-014 d_dstE SHALL be D_rB for icode 2,3,6; 4 for icode 8,9,A,B; else RNONE.
REQ-015 d_dstM SHALL be D_rA for icode 5,B; else RNONE.
REQ-016 d_valA SHALL be D_valP if icode is 7 or 8; else first match of srcA against e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE; else valA.
REQ-017 d_valB SHALL use the same priority chain on srcB (no valP case); else valB.
REQ-018 A source equal to RNONE SHALL never match any destination, including a destination equal to RNONE.
REQ-019 Bubble values: stat=1 (AOK), icode=1 (NOP), ifun=0, valC=valA=valB=0, dstE=dstM=srcA=srcB=RNONE.
REQ-020 Each posedge: E_stall=1 -> all E_* hold; else E_bubble=1 -> E_* load bubble values; else E_* load D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, srcA, srcB.
REQ-021 E_stall SHALL take priority over E_bubble when both are asserted.
REQ-022 Latency: decoded/forwarded values SHALL appear on E_* exactly one clock after capture; srcA/srcB have zero latency.
REQ-023 Forwarding SHALL be purely combinational from current-cycle inputs, with no extra storage.

Reset
REQ-024 RST=1 SHALL immediately, without waiting for CLK, force all E_* outputs to bubble values (REQ-019).
REQ-025 While RST=1, clock edges SHALL not change E_*; first load occurs on the first posedge after RST falls.
REQ-026 RST asserted mid-stall SHALL discard held contents; subsequent stall holds bubble values.

Verification
REQ-027 Reset: assert RST between edges -> E_icode=1, E_dstE=F, E_valA=0 before next edge.
REQ-028 OPQ (icode 6, rA=2, rB=3), valA=5, valB=7, no forwarding match -> next edge E_valA=5, E_valB=7, E_dstE=3, E_dstM=F.
REQ-029 Priority: srcA=2, e_dstE=2/e_valE=0x11, M_dstM=2/m_valM=0x22, W_dstE=2 -> E_valA=0x11; drop e_dstE -> 0x22.
REQ-030 CALL (icode 8, valP=0x40, srcB=4, W_dstE=4, W_valE=0x100) -> E_valA=0x40, E_valB=0x100, E_dstE=4.
REQ-031 Control: E_bubble=1 -> E_icode=1, E_srcA=F; E_stall=1 with E_bubble=1 and changing D inputs -> E_* unchanged.
REQ-032 RNONE: srcA=F, e_dstE=F, e_valE=0x99, valA=0x5 -> E_valA=0x5.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode/execute boundary bundle: decode-stage inputs, register file port,
// forwarding sources, pipeline control and the registered execute fields.
interface decode_stage_if #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4
);
    logic [3:0]          D_stat;
    logic [3:0]          D_icode;
    logic [3:0]          D_ifun;
    logic [ADDR_WID-1:0] D_rA;
    logic [ADDR_WID-1:0] D_rB;
    logic [DATA_WID-1:0] D_valC;
    logic [DATA_WID-1:0] D_valP;

    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;

    logic [ADDR_WID-1:0] e_dstE;
    logic [DATA_WID-1:0] e_valE;
    logic [ADDR_WID-1:0] M_dstM;
    logic [DATA_WID-1:0] m_valM;
    logic [ADDR_WID-1:0] M_dstE;
    logic [DATA_WID-1:0] M_valE;
    logic [ADDR_WID-1:0] W_dstM;
    logic [DATA_WID-1:0] W_valM;
    logic [ADDR_WID-1:0] W_dstE;
    logic [DATA_WID-1:0] W_valE;

    logic                E_stall;
    logic                E_bubble;

    logic [3:0]          E_stat;
    logic [3:0]          E_icode;
    logic [3:0]          E_ifun;
    logic [DATA_WID-1:0] E_valC;
    logic [DATA_WID-1:0] E_valA;
    logic [DATA_WID-1:0] E_valB;
    logic [ADDR_WID-1:0] E_dstE;
    logic [ADDR_WID-1:0] E_dstM;
    logic [ADDR_WID-1:0] E_srcA;
    logic [ADDR_WID-1:0] E_srcB;

    // Pipeline side driving the decode stage
    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  srcA, srcB,
        output valA, valB,
        output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        output W_dstM, W_valM, W_dstE, W_valE,
        output E_stall, E_bubble,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    // Decode stage itself
    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output srcA, srcB,
        input  valA, valB,
        input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
        input  W_dstM, W_valM, W_dstE, W_valE,
        input  E_stall, E_bubble,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 style decode stage: register-ID decode, operand forwarding from the
// later stages, and the decode/execute pipeline register with stall/bubble.
module decode_stage #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4
) (
    input logic           CLK,
    input logic           RST,
    decode_stage_if.slave dec
);
    localparam logic [ADDR_WID-1:0] RNONE = '1;
    localparam logic [ADDR_WID-1:0] RSP   = ADDR_WID'(4);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'h1;

    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [ADDR_WID-1:0] dDstE;
    logic [ADDR_WID-1:0] dDstM;
    logic [DATA_WID-1:0] dValA;
    logic [DATA_WID-1:0] dValB;

    logic [3:0]          eStat;
    logic [3:0]          eIcode;
    logic [3:0]          eIfun;
    logic [DATA_WID-1:0] eValC;
    logic [DATA_WID-1:0] eValA;
    logic [DATA_WID-1:0] eValB;
    logic [ADDR_WID-1:0] eDstE;
    logic [ADDR_WID-1:0] eDstM;
    logic [ADDR_WID-1:0] eSrcA;
    logic [ADDR_WID-1:0] eSrcB;

    // Register-ID decode from the opcode
    always_comb begin
        srcA  = RNONE;
        srcB  = RNONE;
        dDstE = RNONE;
        dDstM = RNONE;
        case (dec.D_icode)
            I_RRMOVQ: begin
                srcA  = dec.D_rA;
                dDstE = dec.D_rB;
            end
            I_IRMOVQ: dDstE = dec.D_rB;
            I_RMMOVQ: begin
                srcA = dec.D_rA;
                srcB = dec.D_rB;
            end
            I_MRMOVQ: begin
                srcB  = dec.D_rB;
                dDstM = dec.D_rA;
            end
            I_OPQ: begin
                srcA  = dec.D_rA;
                srcB  = dec.D_rB;
                dDstE = dec.D_rB;
            end
            I_CALL: begin
                srcB  = RSP;
                dDstE = RSP;
            end
            I_RET: begin
                srcA  = RSP;
                srcB  = RSP;
                dDstE = RSP;
            end
            I_PUSHQ: begin
                srcA  = dec.D_rA;
                srcB  = RSP;
                dDstE = RSP;
            end
            I_POPQ: begin
                srcA  = RSP;
                srcB  = RSP;
                dDstE = RSP;
                dDstM = dec.D_rA;
            end
            default: ;
        endcase
    end

    assign dec.srcA = srcA;
    assign dec.srcB = srcB;

    // Operand A: valP for jump/call, otherwise youngest forwarding hit, otherwise register file.
    // RNONE never forwards, so an idle destination of RNONE cannot hijack an unused operand.
    always_comb begin
        dValA = dec.valA;
        if (dec.D_icode == I_JXX || dec.D_icode == I_CALL)
            dValA = dec.D_valP;
        else if (srcA != RNONE) begin
            if (srcA == dec.e_dstE)      dValA = dec.e_valE;
            else if (srcA == dec.M_dstM) dValA = dec.m_valM;
            else if (srcA == dec.M_dstE) dValA = dec.M_valE;
            else if (srcA == dec.W_dstM) dValA = dec.W_valM;
            else if (srcA == dec.W_dstE) dValA = dec.W_valE;
        end
    end

    // Operand B: same forwarding priority as operand A
    always_comb begin
        dValB = dec.valB;
        if (srcB != RNONE) begin
            if (srcB == dec.e_dstE)      dValB = dec.e_valE;
            else if (srcB == dec.M_dstM) dValB = dec.m_valM;
            else if (srcB == dec.M_dstE) dValB = dec.M_valE;
            else if (srcB == dec.W_dstM) dValB = dec.W_valM;
            else if (srcB == dec.W_dstE) dValB = dec.W_valE;
        end
    end

    // Decode/execute pipeline register; stall wins over bubble, reset forces a bubble
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            eStat  <= STAT_AOK;
            eIcode <= I_NOP;
            eIfun  <= 4'h0;
            eValC  <= '0;
            eValA  <= '0;
            eValB  <= '0;
            eDstE  <= RNONE;
            eDstM  <= RNONE;
            eSrcA  <= RNONE;
            eSrcB  <= RNONE;
        end else if (!dec.E_stall) begin
            if (dec.E_bubble) begin
                eStat  <= STAT_AOK;
                eIcode <= I_NOP;
                eIfun  <= 4'h0;
                eValC  <= '0;
                eValA  <= '0;
                eValB  <= '0;
                eDstE  <= RNONE;
                eDstM  <= RNONE;
                eSrcA  <= RNONE;
                eSrcB  <= RNONE;
            end else begin
                eStat  <= dec.D_stat;
                eIcode <= dec.D_icode;
                eIfun  <= dec.D_ifun;
                eValC  <= dec.D_valC;
                eValA  <= dValA;
                eValB  <= dValB;
                eDstE  <= dDstE;
                eDstM  <= dDstM;
                eSrcA  <= srcA;
                eSrcB  <= srcB;
            end
        end
    end

    assign dec.E_stat  = eStat;
    assign dec.E_icode = eIcode;
    assign dec.E_ifun  = eIfun;
    assign dec.E_valC  = eValC;
    assign dec.E_valA  = eValA;
    assign dec.E_valB  = eValB;
    assign dec.E_dstE  = eDstE;
    assign dec.E_dstM  = eDstM;
    assign dec.E_srcA  = eSrcA;
    assign dec.E_srcB  = eSrcB;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors plus a random run, with expected
// execute-stage fields queued at drive time and compared after the edge.
module tb_decode_stage;
    logic CLK;
    logic RST;

    decode_stage_if #(.DATA_WID(64), .ADDR_WID(4)) dec ();

    decode_stage #(.DATA_WID(64), .ADDR_WID(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .dec (dec)
    );

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } eFields_t;

    localparam eFields_t BUBBLE_E = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0,
                                     valC: 64'h0, valA: 64'h0, valB: 64'h0,
                                     dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};

    int       total = 0;
    int       bad   = 0;
    eFields_t sbQ[$];
    eFields_t lastE;

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fwdModel(input logic [3:0] src, input logic [63:0] rfVal);
        logic [3:0]  dst [5];
        logic [63:0] val [5];
        dst[0] = dec.e_dstE; val[0] = dec.e_valE;
        dst[1] = dec.M_dstM; val[1] = dec.m_valM;
        dst[2] = dec.M_dstE; val[2] = dec.M_valE;
        dst[3] = dec.W_dstM; val[3] = dec.W_valM;
        dst[4] = dec.W_dstE; val[4] = dec.W_valE;
        if (src == 4'hF) return rfVal;
        for (int i = 0; i < 5; i++)
            if (dst[i] == src) return val[i];
        return rfVal;
    endfunction

    function automatic eFields_t modelDecode();
        eFields_t   r;
        logic [3:0] ic;
        ic = dec.D_icode;
        r.stat  = dec.D_stat;
        r.icode = ic;
        r.ifun  = dec.D_ifun;
        r.valC  = dec.D_valC;
        r.srcA  = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? dec.D_rA :
                  (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        r.srcB  = (ic inside {4'h4, 4'h5, 4'h6}) ? dec.D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstE  = (ic inside {4'h2, 4'h3, 4'h6}) ? dec.D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstM  = (ic inside {4'h5, 4'hB}) ? dec.D_rA : 4'hF;
        r.valA  = (ic inside {4'h7, 4'h8}) ? dec.D_valP : fwdModel(r.srcA, dec.valA);
        r.valB  = fwdModel(r.srcB, dec.valB);
        return r;
    endfunction

    task automatic compareE(input string tag, input eFields_t exp);
        chk({tag, ".stat"},  dec.E_stat,  exp.stat);
        chk({tag, ".icode"}, dec.E_icode, exp.icode);
        chk({tag, ".ifun"},  dec.E_ifun,  exp.ifun);
        chk({tag, ".valC"},  dec.E_valC,  exp.valC);
        chk({tag, ".valA"},  dec.E_valA,  exp.valA);
        chk({tag, ".valB"},  dec.E_valB,  exp.valB);
        chk({tag, ".dstE"},  dec.E_dstE,  exp.dstE);
        chk({tag, ".dstM"},  dec.E_dstM,  exp.dstM);
        chk({tag, ".srcA"},  dec.E_srcA,  exp.srcA);
        chk({tag, ".srcB"},  dec.E_srcB,  exp.srcB);
    endtask

    task automatic clearInputs();
        dec.D_stat = 4'h1; dec.D_icode = 4'h1; dec.D_ifun = 4'h0;
        dec.D_rA = 4'hF;   dec.D_rB = 4'hF;
        dec.D_valC = '0;   dec.D_valP = '0;
        dec.valA = '0;     dec.valB = '0;
        dec.e_dstE = 4'hF; dec.e_valE = '0;
        dec.M_dstM = 4'hF; dec.m_valM = '0;
        dec.M_dstE = 4'hF; dec.M_valE = '0;
        dec.W_dstM = 4'hF; dec.W_valM = '0;
        dec.W_dstE = 4'hF; dec.W_valE = '0;
        dec.E_stall = 1'b0; dec.E_bubble = 1'b0;
    endtask

    // Called just after a posedge with inputs already driven: checks the
    // zero-latency read addresses, queues the expected E_* and compares after the next edge.
    task automatic step(input string tag);
        eFields_t m;
        eFields_t exp;
        #1;
        m = modelDecode();
        chk({tag, ".rfSrcA"}, dec.srcA, m.srcA);
        chk({tag, ".rfSrcB"}, dec.srcB, m.srcB);
        if (!dec.E_stall) lastE = dec.E_bubble ? BUBBLE_E : m;
        sbQ.push_back(lastE);
        @(posedge CLK);
        #1;
        chk({tag, ".sbDepth"}, 64'(sbQ.size()), 64'd1);
        if (sbQ.size() != 0) begin
            exp = sbQ.pop_front();
            compareE(tag, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        clearInputs();
        lastE = BUBBLE_E;
        #2;
        compareE("rst0", BUBBLE_E);

        // Edge under reset must not load
        dec.D_icode = 4'h6; dec.D_rA = 4'h2; dec.D_rB = 4'h3;
        dec.valA = 64'h5; dec.valB = 64'h7;
        @(posedge CLK);
        #1;
        compareE("rstHold", BUBBLE_E);
        RST = 1'b0;

        // OPQ with no forwarding hit
        step("opq");
        chk("opq.valAk", dec.E_valA, 64'h5);
        chk("opq.valBk", dec.E_valB, 64'h7);
        chk("opq.dstEk", dec.E_dstE, 64'h3);
        chk("opq.dstMk", dec.E_dstM, 64'hF);

        // Forwarding priority
        clearInputs();
        dec.D_icode = 4'h2; dec.D_rA = 4'h2; dec.D_rB = 4'h5; dec.valA = 64'hAA;
        dec.e_dstE = 4'h2; dec.e_valE = 64'h11;
        dec.M_dstM = 4'h2; dec.m_valM = 64'h22;
        dec.W_dstE = 4'h2; dec.W_valE = 64'h33;
        step("prio1");
        chk("prio1.valAk", dec.E_valA, 64'h11);
        dec.e_dstE = 4'hF;
        step("prio2");
        chk("prio2.valAk", dec.E_valA, 64'h22);

        // CALL: valA from valP, valB forwarded onto RSP
        clearInputs();
        dec.D_icode = 4'h8; dec.D_valP = 64'h40; dec.D_valC = 64'h1234;
        dec.valB = 64'h77; dec.W_dstE = 4'h4; dec.W_valE = 64'h100;
        step("call");
        chk("call.valAk", dec.E_valA, 64'h40);
        chk("call.valBk", dec.E_valB, 64'h100);
        chk("call.dstEk", dec.E_dstE, 64'h4);

        // RNONE source never matches an RNONE destination
        clearInputs();
        dec.D_icode = 4'h3; dec.D_rB = 4'h6; dec.valA = 64'h5;
        dec.e_dstE = 4'hF; dec.e_valE = 64'h99;
        step("rnone");
        chk("rnone.valAk", dec.E_valA, 64'h5);

        // Bubble, then load, then stall with bubble and changing inputs
        clearInputs();
        dec.D_icode = 4'h6; dec.D_rA = 4'h1; dec.D_rB = 4'h7;
        dec.valA = 64'h111; dec.valB = 64'h222; dec.D_stat = 4'h2;
        dec.E_bubble = 1'b1;
        step("bub");
        chk("bub.icodek", dec.E_icode, 64'h1);
        chk("bub.srcAk", dec.E_srcA, 64'hF);
        dec.E_bubble = 1'b0;
        step("load");
        dec.E_stall = 1'b1; dec.E_bubble = 1'b1;
        dec.D_icode = 4'hB; dec.D_rA = 4'h3; dec.valA = 64'h999;
        step("stall1");
        chk("stall1.valAk", dec.E_valA, 64'h111);
        dec.D_icode = 4'h5; dec.valB = 64'h888;
        step("stall2");

        // Reset during a stall discards held contents, stall then holds the bubble
        RST = 1'b1;
        #1;
        compareE("midRst", BUBBLE_E);
        chk("midRst.icodek", dec.E_icode, 64'h1);
        lastE = BUBBLE_E;
        RST = 1'b0;
        step("postRst");

        // Random traffic with mixed control
        for (int n = 0; n < 80; n++) begin
            logic [3:0] pick [6];
            pick[0] = 4'h0; pick[1] = 4'h1; pick[2] = 4'h2;
            pick[3] = 4'h3; pick[4] = 4'h4; pick[5] = 4'hF;
            dec.D_stat  = 4'($urandom_range(1, 4));
            dec.D_icode = 4'($urandom_range(0, 11));
            dec.D_ifun  = 4'($urandom_range(0, 6));
            dec.D_rA    = pick[$urandom_range(0, 5)];
            dec.D_rB    = pick[$urandom_range(0, 5)];
            dec.D_valC  = {$urandom, $urandom};
            dec.D_valP  = {$urandom, $urandom};
            dec.valA    = {$urandom, $urandom};
            dec.valB    = {$urandom, $urandom};
            dec.e_dstE  = pick[$urandom_range(0, 5)]; dec.e_valE = {$urandom, $urandom};
            dec.M_dstM  = pick[$urandom_range(0, 5)]; dec.m_valM = {$urandom, $urandom};
            dec.M_dstE  = pick[$urandom_range(0, 5)]; dec.M_valE = {$urandom, $urandom};
            dec.W_dstM  = pick[$urandom_range(0, 5)]; dec.W_valM = {$urandom, $urandom};
            dec.W_dstE  = pick[$urandom_range(0, 5)]; dec.W_valE = {$urandom, $urandom};
            dec.E_stall  = ($urandom_range(0, 4) == 0);
            dec.E_bubble = ($urandom_range(0, 4) == 0);
            step($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
